// File: rtl/bht_update_sched.sv
// Serializes two streams of resolved-branch updates into one BHT write port,
// and sweeps every BHT row back to weakly-taken after reset or a predictor flush.
module bht_update_sched #(
    parameter int unsigned VLEN       = 64,
    parameter int unsigned NR_ROWS    = 256,
    parameter int unsigned ROW_LSB    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_bp_i,
    input  logic                          debug_mode_i,
    input  logic [1:0]                    upd_valid_i,
    input  logic [1:0][VLEN-1:0]          upd_pc_i,
    input  logic [1:0]                    upd_taken_i,
    output logic [1:0]                    upd_ready_o,
    output logic                          bht_valid_o,
    output logic [VLEN-1:0]               bht_pc_o,
    output logic                          bht_taken_o,
    output logic                          clr_en_o,
    output logic [$clog2(NR_ROWS)-1:0]    clr_row_o,
    output logic                          busy_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);
    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);

    if (NR_ROWS < 2 || (NR_ROWS & (NR_ROWS - 1)) != 0) begin : g_bad_rows
        $error("NR_ROWS must be a power of two >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (ROW_LSB + ROW_BITS > VLEN) begin : g_bad_row_field
        $error("row index field does not fit inside the PC");
    end

    typedef enum logic {SWEEP, RUN} state_e;

    state_e               state_q, state_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic                 clr_en_q, clr_en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 bht_valid_q, bht_valid_d;
    logic [VLEN-1:0]      bht_pc_q, bht_pc_d;
    logic                 bht_taken_q, bht_taken_d;
    logic [1:0]           ready_q, ready_d;
    logic [15:0]          drop_q, drop_d;

    logic [VLEN-1:0]      mem_pc_q [FIFO_DEPTH];
    logic                 mem_tk_q [FIFO_DEPTH];

    logic [1:0]           push, drop;
    logic                 pop;
    logic [1:0]           n_push, n_drop;
    logic [CNT_W-1:0]     remain, free_d;
    logic [VLEN-1:0]      first_pc;
    logic                 first_tk;

    // Sweep sequencer: a cleared-row counter that hands over to RUN after the last row.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        clr_en_d = 1'b0;
        case (state_q)
            SWEEP: begin
                if (flush_bp_i) begin
                    row_d    = '0;
                    clr_en_d = 1'b1;
                end else if (!clr_en_q) begin
                    // First cycle out of reset: row 0 is issued next without advancing.
                    clr_en_d = 1'b1;
                end else if (row_q == LAST_ROW) begin
                    state_d = RUN;
                    row_d   = '0;
                end else begin
                    row_d    = row_q + ROW_BITS'(1);
                    clr_en_d = 1'b1;
                end
            end
            RUN: begin
                if (flush_bp_i) begin
                    state_d  = SWEEP;
                    row_d    = '0;
                    clr_en_d = 1'b1;
                end
            end
            default: begin
                state_d  = SWEEP;
                row_d    = '0;
                clr_en_d = 1'b1;
            end
        endcase
    end

    assign push   = upd_valid_i &  ready_q & {2{~debug_mode_i}};
    assign drop   = upd_valid_i & ~ready_q & {2{~debug_mode_i}};
    assign pop    = (state_q == RUN) && (cnt_q != '0);
    assign n_push = {1'b0, push[0]} + {1'b0, push[1]};
    assign n_drop = {1'b0, drop[0]} + {1'b0, drop[1]};

    // Queue bookkeeping, next output word and next-cycle readiness.
    always_comb begin
        first_pc    = push[0] ? upd_pc_i[0]    : upd_pc_i[1];
        first_tk    = push[0] ? upd_taken_i[0] : upd_taken_i[1];
        remain      = cnt_q - CNT_W'(pop);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(n_push);
        cnt_d       = remain + CNT_W'(n_push);
        bht_pc_d    = bht_pc_q;
        bht_taken_d = bht_taken_q;
        ready_d     = 2'b00;
        free_d      = '0;

        if (state_q == RUN && flush_bp_i) begin
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end

        bht_valid_d = (state_d == RUN) && (cnt_d != '0);
        if (bht_valid_d) begin
            // Writes only land in free slots, so a surviving head is never overwritten.
            if (remain != '0) begin
                bht_pc_d    = mem_pc_q[rd_ptr_d];
                bht_taken_d = mem_tk_q[rd_ptr_d];
            end else begin
                bht_pc_d    = first_pc;
                bht_taken_d = first_tk;
            end
        end

        if (state_d == RUN) begin
            free_d = DEPTH_C - cnt_d;
            if (free_d >= CNT_W'(2)) begin
                ready_d = 2'b11;
            end else if (free_d == CNT_W'(1)) begin
                ready_d = 2'b01;
            end
        end

        if (drop_q > (16'hFFFF - 16'(n_drop))) begin
            drop_d = 16'hFFFF;
        end else begin
            drop_d = drop_q + 16'(n_drop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SWEEP;
            row_q       <= '0;
            clr_en_q    <= 1'b0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            bht_valid_q <= 1'b0;
            bht_pc_q    <= '0;
            bht_taken_q <= 1'b0;
            ready_q     <= 2'b00;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            clr_en_q    <= clr_en_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            bht_valid_q <= bht_valid_d;
            bht_pc_q    <= bht_pc_d;
            bht_taken_q <= bht_taken_d;
            ready_q     <= ready_d;
            drop_q      <= drop_d;
        end
    end

    // Port 0 takes the tail slot first so it is drained ahead of port 1.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (push[0]) begin
                mem_pc_q[wr_ptr_q] <= upd_pc_i[0];
                mem_tk_q[wr_ptr_q] <= upd_taken_i[0];
            end
            if (push[1]) begin
                mem_pc_q[push[0] ? wr_ptr_q + PTR_W'(1) : wr_ptr_q] <= upd_pc_i[1];
                mem_tk_q[push[0] ? wr_ptr_q + PTR_W'(1) : wr_ptr_q] <= upd_taken_i[1];
            end
        end
    end

    assign upd_ready_o = ready_q;
    assign bht_valid_o = bht_valid_q;
    assign bht_pc_o    = bht_pc_q;
    assign bht_taken_o = bht_taken_q;
    assign clr_en_o    = clr_en_q;
    assign clr_row_o   = row_q;
    assign busy_o      = (state_q == SWEEP);
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched (16 rows, 4-entry queue): sweep, ordering,
// backpressure/drops, flush, debug gating and mid-sweep reset.
module tb_bht_update_sched;

    localparam int unsigned VLEN = 64;
    localparam int unsigned NR_ROWS = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  flush_bp_i;
    logic                  debug_mode_i;
    logic [1:0]            upd_valid_i;
    logic [1:0][VLEN-1:0]  upd_pc_i;
    logic [1:0]            upd_taken_i;
    logic [1:0]            upd_ready_o;
    logic                  bht_valid_o;
    logic [VLEN-1:0]       bht_pc_o;
    logic                  bht_taken_o;
    logic                  clr_en_o;
    logic [3:0]            clr_row_o;
    logic                  busy_o;
    logic [15:0]           drop_cnt_o;

    int checks = 0;
    int failures = 0;

    bht_update_sched #(
        .VLEN(VLEN), .NR_ROWS(NR_ROWS), .ROW_LSB(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_ready_o(upd_ready_o), .bht_valid_o(bht_valid_o), .bht_pc_o(bht_pc_o),
        .bht_taken_o(bht_taken_o), .clr_en_o(clr_en_o), .clr_row_o(clr_row_o),
        .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic [1:0] v, input logic [63:0] p0, input logic t0,
                           input logic [63:0] p1, input logic t1);
        upd_valid_i    = v;
        upd_pc_i[0]    = p0;
        upd_pc_i[1]    = p1;
        upd_taken_i[0] = t0;
        upd_taken_i[1] = t1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] pc, input logic tk);
        chk({tag, "_valid"}, 64'(bht_valid_o), 64'(v));
        if (v) begin
            chk({tag, "_pc"}, bht_pc_o, pc);
            chk({tag, "_taken"}, 64'(bht_taken_o), 64'(tk));
        end
    endtask

    initial begin
        rst_i = 1'b1;
        flush_bp_i = 1'b0;
        debug_mode_i = 1'b0;
        set_upd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0);
        repeat (3) tick();

        // reset values
        chk("rst_clr_en", 64'(clr_en_o), 64'd0);
        chk("rst_clr_row", 64'(clr_row_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd1);
        chk("rst_ready", 64'(upd_ready_o), 64'd0);
        chk("rst_bht_valid", 64'(bht_valid_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);

        // initial sweep of all 16 rows
        rst_i = 1'b0;
        tick();
        for (int r = 0; r < 16; r++) begin
            chk("sweep_clr_en", 64'(clr_en_o), 64'd1);
            chk("sweep_row", 64'(clr_row_o), 64'(r));
            chk("sweep_busy", 64'(busy_o), 64'd1);
            chk("sweep_ready", 64'(upd_ready_o), 64'd0);
            chk("sweep_no_bht", 64'(bht_valid_o), 64'd0);
            tick();
        end
        chk("run_busy", 64'(busy_o), 64'd0);
        chk("run_ready", 64'(upd_ready_o), 64'd3);
        chk("run_clr_en", 64'(clr_en_o), 64'd0);

        // dual push, port 0 first
        set_upd(2'b11, 64'h100, 1'b1, 64'h204, 1'b0);
        tick();
        set_upd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0);
        chk_out("pair_first", 1'b1, 64'h100, 1'b1);
        chk("pair_ready1", 64'(upd_ready_o), 64'd3);
        tick();
        chk_out("pair_second", 1'b1, 64'h204, 1'b0);
        tick();
        chk_out("pair_idle", 1'b0, 64'h0, 1'b0);

        // sustained dual traffic: queue fills to 3, port 1 loses readiness
        set_upd(2'b11, 64'h300, 1'b1, 64'h304, 1'b0);
        chk("bp_ready_c1", 64'(upd_ready_o), 64'd3);
        tick();
        chk("bp_ready_c2", 64'(upd_ready_o), 64'd3);
        chk_out("bp_out_c2", 1'b1, 64'h300, 1'b1);
        set_upd(2'b11, 64'h310, 1'b0, 64'h314, 1'b1);
        tick();
        chk("bp_ready_c3", 64'(upd_ready_o), 64'd1);
        chk_out("bp_out_c3", 1'b1, 64'h304, 1'b0);
        set_upd(2'b11, 64'h320, 1'b1, 64'h324, 1'b1);
        tick();
        set_upd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("bp_drop", 64'(drop_cnt_o), 64'd1);
        chk("bp_ready_c4", 64'(upd_ready_o), 64'd1);
        chk_out("bp_out_c4", 1'b1, 64'h310, 1'b0);
        tick();
        chk("bp_ready_c5", 64'(upd_ready_o), 64'd3);
        chk_out("bp_out_c5", 1'b1, 64'h314, 1'b1);
        tick();
        chk_out("bp_out_c6", 1'b1, 64'h320, 1'b1);
        tick();
        chk_out("bp_out_c7", 1'b0, 64'h0, 1'b0);
        chk("bp_drop_final", 64'(drop_cnt_o), 64'd1);

        // debug mode: updates ignored entirely
        debug_mode_i = 1'b1;
        set_upd(2'b11, 64'h500, 1'b1, 64'h504, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dbg_no_bht", 64'(bht_valid_o), 64'd0);
            chk("dbg_drop", 64'(drop_cnt_o), 64'd1);
        end
        debug_mode_i = 1'b0;
        set_upd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0);

        // flush with 3 queued entries
        set_upd(2'b11, 64'h600, 1'b1, 64'h604, 1'b0);
        tick();
        chk_out("fl_out_d1", 1'b1, 64'h600, 1'b1);
        set_upd(2'b11, 64'h610, 1'b1, 64'h614, 1'b1);
        tick();
        chk_out("fl_out_d2", 1'b1, 64'h604, 1'b0);
        set_upd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0);
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        chk("fl_bht_valid", 64'(bht_valid_o), 64'd0);
        chk("fl_busy", 64'(busy_o), 64'd1);
        chk("fl_clr_en", 64'(clr_en_o), 64'd1);
        chk("fl_row0", 64'(clr_row_o), 64'd0);
        chk("fl_ready", 64'(upd_ready_o), 64'd0);
        for (int r = 1; r <= 7; r++) begin
            tick();
            chk("fl_row", 64'(clr_row_o), 64'(r));
            chk("fl_no_bht", 64'(bht_valid_o), 64'd0);
        end
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        chk("fl2_row0", 64'(clr_row_o), 64'd0);
        chk("fl2_busy", 64'(busy_o), 64'd1);

        // updates during a sweep are dropped and counted (1 + 2 + 2 = 5)
        set_upd(2'b11, 64'h700, 1'b1, 64'h704, 1'b1);
        tick();
        chk("sw_drop3", 64'(drop_cnt_o), 64'd3);
        tick();
        set_upd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("sw_drop5", 64'(drop_cnt_o), 64'd5);
        chk("sw_row2", 64'(clr_row_o), 64'd2);
        for (int r = 3; r <= 9; r++) begin
            tick();
            chk("sw_row", 64'(clr_row_o), 64'(r));
            chk("sw_no_bht", 64'(bht_valid_o), 64'd0);
        end
        chk("mid_drop5", 64'(drop_cnt_o), 64'd5);

        // reset mid-sweep at row 9, overriding a concurrent flush and updates
        rst_i = 1'b1;
        flush_bp_i = 1'b1;
        set_upd(2'b11, 64'h800, 1'b1, 64'h804, 1'b1);
        tick();
        rst_i = 1'b0;
        flush_bp_i = 1'b0;
        set_upd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("mrst_clr_en", 64'(clr_en_o), 64'd0);
        chk("mrst_drop", 64'(drop_cnt_o), 64'd0);
        chk("mrst_row", 64'(clr_row_o), 64'd0);
        chk("mrst_busy", 64'(busy_o), 64'd1);
        chk("mrst_ready", 64'(upd_ready_o), 64'd0);
        tick();
        chk("mrst_first_en", 64'(clr_en_o), 64'd1);
        chk("mrst_first_row", 64'(clr_row_o), 64'd0);
        for (int r = 1; r < 16; r++) begin
            tick();
            chk("mrst_row_seq", 64'(clr_row_o), 64'(r));
            chk("mrst_no_bht", 64'(bht_valid_o), 64'd0);
        end
        tick();
        chk("end_busy", 64'(busy_o), 64'd0);
        chk("end_ready", 64'(upd_ready_o), 64'd3);
        chk("end_no_stale", 64'(bht_valid_o), 64'd0);
        tick();
        chk("end_no_stale2", 64'(bht_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
